// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arb_pkg
// Description : Shared widths, client count, FSM encoding and the latched
//               transaction record for the two-client SDRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

  localparam int ADDR_W      = 11;
  localparam int DATA_W      = 16;
  localparam int NUM_CLIENTS = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  // One client transaction as presented to the SDRAM controller
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] x;
    logic [ADDR_W-1:0] y;
    logic [DATA_W-1:0] data;
  } sdram_txn_t;

endpackage : sdram_arb_pkg
`default_nettype wire

// File: rtl/sdram_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : sdram_rr_picker
// Description : Combinational grant selection for two clients. A lone
//               requester always wins; ties go to the client not served
//               last (round-robin) or to client 0 (fixed priority).
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_rr_picker
  import sdram_arb_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic                   last_grant,
  output logic                   grant,
  output logic                   grant_valid
);

  // Resolve the winning client index from the request pair
  always_comb begin
    grant_valid = |req;
    grant       = 1'b0;
    case (req)
      2'b10:   grant = 1'b1;
      2'b11:   grant = (ROUND_ROBIN != 0) ? ~last_grant : 1'b0;
      default: grant = 1'b0;
    endcase
  end

endmodule : sdram_rr_picker
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter
// Description : Two-client arbiter in front of a single SDRAM controller.
//               Latches the winning client's transaction, forwards it with a
//               level request, and returns completion to the owner with a
//               four-phase handshake. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic              osc_50,
  input  logic              reset_50m,
  // client 0
  input  logic              c0_command,
  input  logic              c0_write,
  input  logic [ADDR_W-1:0] c0_x,
  input  logic [ADDR_W-1:0] c0_y,
  input  logic [DATA_W-1:0] c0_data_write,
  output logic              c0_response,
  output logic [DATA_W-1:0] c0_data_read,
  // client 1
  input  logic              c1_command,
  input  logic              c1_write,
  input  logic [ADDR_W-1:0] c1_x,
  input  logic [ADDR_W-1:0] c1_y,
  input  logic [DATA_W-1:0] c1_data_write,
  output logic              c1_response,
  output logic [DATA_W-1:0] c1_data_read,
  // SDRAM controller
  output logic              sdram_command,
  output logic              sdram_write,
  output logic [ADDR_W-1:0] sdram_x,
  output logic [ADDR_W-1:0] sdram_y,
  output logic [DATA_W-1:0] sdram_data_write,
  input  logic              sdram_response,
  input  logic [DATA_W-1:0] sdram_data_read
);

  arb_state_e        state_q,         state_d;
  logic              owner_q,         owner_d;
  logic              last_grant_q,    last_grant_d;
  logic              sdram_command_q, sdram_command_d;
  logic              c0_response_q,   c0_response_d;
  logic              c1_response_q,   c1_response_d;
  sdram_txn_t        txn_q,           txn_d;
  logic [DATA_W-1:0] c0_data_read_q,  c0_data_read_d;
  logic [DATA_W-1:0] c1_data_read_q,  c1_data_read_d;

  logic [NUM_CLIENTS-1:0] req;
  logic                   pick_grant;
  logic                   pick_valid;
  logic                   owner_cmd;
  sdram_txn_t             c0_txn;
  sdram_txn_t             c1_txn;

  assign req       = {c1_command, c0_command};
  assign owner_cmd = owner_q ? c1_command : c0_command;
  assign c0_txn    = '{write: c0_write, x: c0_x, y: c0_y, data: c0_data_write};
  assign c1_txn    = '{write: c1_write, x: c1_x, y: c1_y, data: c1_data_write};

  sdram_rr_picker #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_picker (
    .req         (req),
    .last_grant  (last_grant_q),
    .grant       (pick_grant),
    .grant_valid (pick_valid)
  );

  // Next-state and next-output computation for the IDLE/BUSY/DONE handshake
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    sdram_command_d = sdram_command_q;
    c0_response_d   = c0_response_q;
    c1_response_d   = c1_response_q;
    txn_d           = txn_q;
    c0_data_read_d  = c0_data_read_q;
    c1_data_read_d  = c1_data_read_q;

    case (state_q)
      ST_IDLE: begin
        // A lingering controller response (refresh, or stale after reset)
        // blocks arbitration so a new request is never mistaken as done.
        if (pick_valid && !sdram_response) begin
          owner_d         = pick_grant;
          last_grant_d    = pick_grant;
          txn_d           = pick_grant ? c1_txn : c0_txn;
          sdram_command_d = 1'b1;
          state_d         = ST_BUSY;
        end
      end

      ST_BUSY: begin
        // Completes even if the owner already dropped its command
        if (sdram_response) begin
          sdram_command_d = 1'b0;
          state_d         = ST_DONE;
          if (owner_q) begin
            c1_response_d = 1'b1;
            if (!txn_q.write) c1_data_read_d = sdram_data_read;
          end else begin
            c0_response_d = 1'b1;
            if (!txn_q.write) c0_data_read_d = sdram_data_read;
          end
        end
      end

      ST_DONE: begin
        // Response follows the owner's command; leaving also waits for the
        // controller to release its own response.
        if (!owner_cmd) begin
          c0_response_d = 1'b0;
          c1_response_d = 1'b0;
          if (!sdram_response) state_d = ST_IDLE;
        end
      end

      default: begin
        state_d         = ST_IDLE;
        sdram_command_d = 1'b0;
        c0_response_d   = 1'b0;
        c1_response_d   = 1'b0;
      end
    endcase
  end

  // State and registered-output flops with synchronous reset
  always_ff @(posedge osc_50) begin
    if (reset_50m) begin
      state_q         <= ST_IDLE;
      owner_q         <= 1'b0;
      last_grant_q    <= 1'b1;
      sdram_command_q <= 1'b0;
      c0_response_q   <= 1'b0;
      c1_response_q   <= 1'b0;
      txn_q           <= '0;
      c0_data_read_q  <= '0;
      c1_data_read_q  <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_grant_q    <= last_grant_d;
      sdram_command_q <= sdram_command_d;
      c0_response_q   <= c0_response_d;
      c1_response_q   <= c1_response_d;
      txn_q           <= txn_d;
      c0_data_read_q  <= c0_data_read_d;
      c1_data_read_q  <= c1_data_read_d;
    end
  end

  assign sdram_command    = sdram_command_q;
  assign sdram_write      = txn_q.write;
  assign sdram_x          = txn_q.x;
  assign sdram_y          = txn_q.y;
  assign sdram_data_write = txn_q.data;
  assign c0_response      = c0_response_q;
  assign c1_response      = c1_response_q;
  assign c0_data_read     = c0_data_read_q;
  assign c1_data_read     = c1_data_read_q;

endmodule : sdram_arbiter
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_arbiter
// Description : Directed bench for sdram_arbiter: a vector table of single
//               transactions plus hand-written multi-cycle sequences, with a
//               behavioural SDRAM controller model. A second instance runs
//               with fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

  localparam int LATENCY = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  // round-robin DUT signals
  logic        c0_command = 0, c0_write = 0, c1_command = 0, c1_write = 0;
  logic [10:0] c0_x = 0, c0_y = 0, c1_x = 0, c1_y = 0;
  logic [15:0] c0_data_write = 0, c1_data_write = 0;
  logic        c0_response, c1_response;
  logic [15:0] c0_data_read, c1_data_read;
  logic        sdram_command, sdram_write;
  logic [10:0] sdram_x, sdram_y;
  logic [15:0] sdram_data_write;
  logic        sdram_response;
  logic [15:0] sdram_data_read;

  // controller model state
  logic        model_en = 1'b1;
  logic        m_resp   = 1'b0;
  logic        man_resp = 1'b0;
  logic [15:0] m_rdata  = 16'h0000;
  int          hold_extra = 0;
  int          cnt = 0;
  int          hold_cnt = 0;
  logic [15:0] mem [logic [21:0]];

  assign sdram_response  = model_en ? m_resp : man_resp;
  assign sdram_data_read = m_rdata;

  // fixed-priority DUT signals
  logic        fp_c0_command = 0, fp_c1_command = 0, fp_sdram_response = 0;
  logic [10:0] fp_c0_x = 11'h001, fp_c1_x = 11'h002, fp_y = 11'h000;
  logic [15:0] fp_wd = 16'h0000, fp_rd = 16'h0000;
  logic        fp_c0_response, fp_c1_response, fp_sdram_command, fp_sdram_write;
  logic [15:0] fp_c0_data_read, fp_c1_data_read, fp_sdram_data_write;
  logic [10:0] fp_sdram_x, fp_sdram_y;
  logic        fp_one = 1'b1;

  int checks = 0;
  int errors = 0;

  sdram_arbiter #(.ROUND_ROBIN(1)) u_dut (
    .osc_50(clk), .reset_50m(rst),
    .c0_command(c0_command), .c0_write(c0_write), .c0_x(c0_x), .c0_y(c0_y),
    .c0_data_write(c0_data_write), .c0_response(c0_response), .c0_data_read(c0_data_read),
    .c1_command(c1_command), .c1_write(c1_write), .c1_x(c1_x), .c1_y(c1_y),
    .c1_data_write(c1_data_write), .c1_response(c1_response), .c1_data_read(c1_data_read),
    .sdram_command(sdram_command), .sdram_write(sdram_write), .sdram_x(sdram_x),
    .sdram_y(sdram_y), .sdram_data_write(sdram_data_write),
    .sdram_response(sdram_response), .sdram_data_read(sdram_data_read)
  );

  sdram_arbiter #(.ROUND_ROBIN(0)) u_fp (
    .osc_50(clk), .reset_50m(rst),
    .c0_command(fp_c0_command), .c0_write(fp_one), .c0_x(fp_c0_x), .c0_y(fp_y),
    .c0_data_write(fp_wd), .c0_response(fp_c0_response), .c0_data_read(fp_c0_data_read),
    .c1_command(fp_c1_command), .c1_write(fp_one), .c1_x(fp_c1_x), .c1_y(fp_y),
    .c1_data_write(fp_wd), .c1_response(fp_c1_response), .c1_data_read(fp_c1_data_read),
    .sdram_command(fp_sdram_command), .sdram_write(fp_sdram_write), .sdram_x(fp_sdram_x),
    .sdram_y(fp_sdram_y), .sdram_data_write(fp_sdram_data_write),
    .sdram_response(fp_sdram_response), .sdram_data_read(fp_rd)
  );

  // Behavioural controller: answers after LATENCY cycles, releases the
  // response hold_extra cycles after the request drops (refresh emulation).
  // Unwritten locations read back as addr[15:0] ^ 16'h5A5A.
  always @(negedge clk) begin
    if (!model_en) begin
      cnt      = 0;
      hold_cnt = 0;
      m_resp   = 1'b0;
    end else if (hold_cnt > 0) begin
      hold_cnt = hold_cnt - 1;
      if (hold_cnt == 0) m_resp = 1'b0;
    end else if (m_resp) begin
      if (!sdram_command) begin
        if (hold_extra == 0) m_resp = 1'b0;
        else hold_cnt = hold_extra;
      end
    end else if (sdram_command) begin
      cnt = cnt + 1;
      if (cnt >= LATENCY) begin
        logic [21:0] a;
        cnt = 0;
        a = {sdram_y, sdram_x};
        if (sdram_write) begin
          mem[a]  = sdram_data_write;
          m_rdata = 16'hDEAD;
        end else begin
          m_rdata = mem.exists(a) ? mem[a] : (a[15:0] ^ 16'h5A5A);
        end
        m_resp = 1'b1;
      end
    end else begin
      cnt = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running after 400000 time units, expected to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_any_resp(input string nm);
    int n = 0;
    while (!(c0_response || c1_response) && n < 60) begin
      tick();
      n++;
    end
    if (!(c0_response || c1_response)) begin
      checks++;
      errors++;
      $display("FAIL %s.wait: got no client response in 60 cycles, expected one", nm);
    end
  endtask

  task automatic settle();
    int n = 0;
    while ((sdram_response || sdram_command || c0_response || c1_response) && n < 60) begin
      tick();
      n++;
    end
    if (sdram_response || sdram_command || c0_response || c1_response) begin
      checks++;
      errors++;
      $display("FAIL settle: got bus still active after 60 cycles, expected idle");
    end
    tick();
  endtask

  task automatic chk_reset_state(input string t);
    chk({t, ".sdram_command"},    32'(sdram_command),    32'h0);
    chk({t, ".responses"},        32'({c1_response, c0_response}), 32'h0);
    chk({t, ".sdram_write"},      32'(sdram_write),      32'h0);
    chk({t, ".sdram_x"},          32'(sdram_x),          32'h0);
    chk({t, ".sdram_y"},          32'(sdram_y),          32'h0);
    chk({t, ".sdram_data_write"}, 32'(sdram_data_write), 32'h0);
    chk({t, ".c0_data_read"},     32'(c0_data_read),     32'h0);
    chk({t, ".c1_data_read"},     32'(c1_data_read),     32'h0);
  endtask

  typedef struct {
    logic        c0_req, c1_req, c0_wr, c1_wr;
    logic [10:0] c0x, c0y, c1x, c1y;
    logic [15:0] c0wd, c1wd;
    logic        exp_grant;
    logic [15:0] exp_d0, exp_d1;
  } vec_t;

  task automatic run_vec(input int idx, input vec_t v);
    string       t;
    logic [10:0] ex, ey;
    logic        ew;
    logic [15:0] ed;
    t  = $sformatf("vec%0d", idx);
    ex = v.exp_grant ? v.c1x  : v.c0x;
    ey = v.exp_grant ? v.c1y  : v.c0y;
    ew = v.exp_grant ? v.c1_wr : v.c0_wr;
    ed = v.exp_grant ? v.c1wd : v.c0wd;
    c0_write = v.c0_wr; c0_x = v.c0x; c0_y = v.c0y; c0_data_write = v.c0wd;
    c1_write = v.c1_wr; c1_x = v.c1x; c1_y = v.c1y; c1_data_write = v.c1wd;
    c0_command = v.c0_req;
    c1_command = v.c1_req;
    tick();
    chk({t, ".cmd_next_cycle"}, 32'(sdram_command), 32'h1);
    wait_any_resp(t);
    chk({t, ".grant"},            32'({c1_response, c0_response}), v.exp_grant ? 32'h2 : 32'h1);
    chk({t, ".sdram_x"},          32'(sdram_x),          32'(ex));
    chk({t, ".sdram_y"},          32'(sdram_y),          32'(ey));
    chk({t, ".sdram_write"},      32'(sdram_write),      32'(ew));
    chk({t, ".sdram_data_write"}, 32'(sdram_data_write), 32'(ed));
    chk({t, ".cmd_dropped"},      32'(sdram_command),    32'h0);
    chk({t, ".c0_data_read"},     32'(c0_data_read),     32'(v.exp_d0));
    chk({t, ".c1_data_read"},     32'(c1_data_read),     32'(v.exp_d1));
    c0_command = 1'b0;
    c1_command = 1'b0;
    tick();
    tick();
    chk({t, ".resp_cleared"}, 32'({c1_response, c0_response}), 32'h0);
    settle();
  endtask

  vec_t vecs[7];

  initial begin
    // c0/c1 req, c0/c1 write, c0 x,y, c1 x,y, c0/c1 wdata, winner, d0, d1
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 11'h123, 11'h045, 11'h000, 11'h000, 16'hBEEF, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 11'h000, 11'h123, 11'h045, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 11'h010, 11'h001, 11'h300, 11'h003, 16'h0000, 16'h7777, 1'b0, 16'h524A, 16'hBEEF};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 11'h010, 11'h001, 11'h200, 11'h002, 16'h0000, 16'h1234, 1'b1, 16'h524A, 16'hBEEF};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 11'h000, 11'h200, 11'h002, 16'h0000, 16'h0000, 1'b1, 16'h524A, 16'h1234};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 11'h7FF, 11'h7FF, 11'h000, 11'h000, 16'hA5A5, 16'h0000, 1'b0, 16'h524A, 16'h1234};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 11'h7FF, 11'h7FF, 11'h000, 11'h000, 16'h0000, 16'h0000, 1'b0, 16'hA5A5, 16'h1234};

    // ---- reset state ----
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk_reset_state("reset");

    // ---- vector table ----
    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // ---- response held as during refresh: c1 must wait ----
    begin
      logic early;
      int   n;
      hold_extra = 20;
      c0_write = 1'b1; c0_x = 11'h055; c0_y = 11'h001; c0_data_write = 16'h0F0F;
      c0_command = 1'b1;
      wait_any_resp("refresh.c0");
      chk("refresh.c0_grant", 32'({c1_response, c0_response}), 32'h1);
      c0_command = 1'b0;
      c1_write = 1'b0; c1_x = 11'h055; c1_y = 11'h001;
      c1_command = 1'b1;
      early = 1'b0;
      n = 0;
      while (sdram_response && n < 40) begin
        if (sdram_command) early = 1'b1;
        tick();
        n++;
      end
      hold_extra = 0;
      chk("refresh.no_grant_while_resp", 32'(early), 32'h0);
      chk("refresh.resp_was_held", 32'(n >= 15), 32'h1);
      wait_any_resp("refresh.c1");
      chk("refresh.c1_grant", 32'({c1_response, c0_response}), 32'h2);
      chk("refresh.c1_data", 32'(c1_data_read), 32'h0F0F);
      c1_command = 1'b0;
      settle();
    end

    // ---- owner drops its command mid-BUSY ----
    c0_write = 1'b0; c0_x = 11'h0AA; c0_y = 11'h000;
    c0_command = 1'b1;
    tick();
    tick();
    chk("drop.busy", 32'(sdram_command), 32'h1);
    c0_command = 1'b0;
    wait_any_resp("drop");
    chk("drop.pulse_high", 32'({c1_response, c0_response}), 32'h1);
    chk("drop.data", 32'(c0_data_read), 32'h5AF0);
    tick();
    chk("drop.pulse_low", 32'(c0_response), 32'h0);
    settle();

    // ---- reset in BUSY followed by a stale controller response ----
    model_en = 1'b0;
    man_resp = 1'b0;
    c1_write = 1'b0; c1_x = 11'h123; c1_y = 11'h045;
    c1_command = 1'b1;
    tick();
    tick();
    chk("rstbusy.busy", 32'(sdram_command), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    man_resp = 1'b1;
    chk_reset_state("rstbusy");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rstbusy.stale%0d", i), 32'({sdram_command, c1_response, c0_response}), 32'h0);
    end
    man_resp = 1'b0;
    model_en = 1'b1;
    wait_any_resp("rstbusy.next");
    chk("rstbusy.next_grant", 32'({c1_response, c0_response}), 32'h2);
    chk("rstbusy.next_data", 32'(c1_data_read), 32'hBEEF);
    c1_command = 1'b0;
    settle();

    // ---- round-robin: both held from reset, four grants ----
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    c0_write = 1'b1; c0_x = 11'h001; c0_y = 11'h000; c0_data_write = 16'h1111;
    c1_write = 1'b1; c1_x = 11'h002; c1_y = 11'h000; c1_data_write = 16'h2222;
    c0_command = 1'b1;
    c1_command = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic who;
      wait_any_resp($sformatf("rr%0d", i));
      who = c1_response;
      chk($sformatf("rr%0d.order", i), 32'(who), 32'(i % 2));
      if (who) c1_command = 1'b0; else c0_command = 1'b0;
      tick();
      tick();
      if (i < 3) begin
        if (who) c1_command = 1'b1; else c0_command = 1'b1;
      end else begin
        c0_command = 1'b0;
        c1_command = 1'b0;
      end
    end
    settle();

    // ---- fixed priority: c0 wins every tie until it stops requesting ----
    fp_c0_command = 1'b1;
    fp_c1_command = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic who;
      int   n = 0;
      while (!fp_sdram_command && n < 10) begin
        tick();
        n++;
      end
      chk($sformatf("fp%0d.cmd", i), 32'(fp_sdram_command), 32'h1);
      who = (fp_sdram_x == 11'h002);
      chk($sformatf("fp%0d.order", i), 32'(who), (i < 3) ? 32'h0 : 32'h1);
      fp_sdram_response = 1'b1;
      tick();
      chk($sformatf("fp%0d.resp", i), 32'({fp_c1_response, fp_c0_response}), who ? 32'h2 : 32'h1);
      fp_sdram_response = 1'b0;
      if (who) fp_c1_command = 1'b0; else fp_c0_command = 1'b0;
      tick();
      if (i < 2) fp_c0_command = 1'b1;
    end
    tick();
    chk("fp.idle", 32'({fp_sdram_command, fp_c1_response, fp_c0_response}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sdram_arbiter
`default_nettype wire
